// File: rtl/qec_router_pkg.sv
// Shared arbiter definitions: FSM state encoding and leaf-index width helper.
package qec_router_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_LEAVES = 16;

    // Index width for n leaves, never narrower than one bit.
    function automatic int unsigned leaf_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned LEAF_IDX_W = leaf_idx_w(MAX_LEAVES);

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo N.
module rr_priority_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    always_comb begin
        w_rot = N'({i_req, i_req} >> i_ptr);
        o_any = |i_req;
        // Scan from the far end so the smallest offset from the pointer wins.
        w_off = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_rot[N-1-i]) begin
                w_off = IDX_W'(N - 1 - i);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W + 1)'(N)) begin
            w_sum = w_sum - (IDX_W + 1)'(N);
        end
        o_idx        = w_sum[IDX_W-1:0];
        o_gnt        = '0;
        o_gnt[o_idx] = o_any;
    end

endmodule

// File: rtl/leaf_uplink_arbiter.sv
// Round-robin burst arbiter merging NUM_LEAVES leaf channels into one registered uplink.
// Optional per-leaf accepted-word counters on grant_count when LEAF_UPLINK_ARBITER_STATS_EN is defined.
module leaf_uplink_arbiter
    import qec_router_pkg::*;
#(
    parameter int unsigned NUM_LEAVES    = 4,
    parameter int unsigned CHANNEL_WIDTH = 64,
    parameter int unsigned MAX_BURST     = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CHANNEL_WIDTH*NUM_LEAVES-1:0] up_rx_data,
    input  logic [NUM_LEAVES-1:0]               up_rx_valid,
    output logic [NUM_LEAVES-1:0]               up_rx_ready,
    output logic [CHANNEL_WIDTH-1:0]            out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [leaf_idx_w(NUM_LEAVES)-1:0]   out_src
`ifdef LEAF_UPLINK_ARBITER_STATS_EN
    ,
    output logic [32*NUM_LEAVES-1:0]            grant_count
`endif
);

    localparam int unsigned      IDX_W      = leaf_idx_w(NUM_LEAVES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LEAVES - 1);
    localparam logic [7:0]       BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t r_state, w_state_nxt;
    logic [IDX_W-1:0]         r_grant, w_grant_nxt;
    logic [IDX_W-1:0]         r_last_grant, w_last_nxt;
    logic [7:0]               r_burst_cnt, w_cnt_nxt;
    logic [CHANNEL_WIDTH-1:0] r_out_data;
    logic                     r_out_valid;
    logic [IDX_W-1:0]         r_out_src;

    logic                     w_can_accept;
    logic                     w_arb;
    logic                     w_xfer;
    logic                     w_burst_end;
    logic [IDX_W-1:0]         w_ptr_base;
    logic [IDX_W-1:0]         w_ptr;
    logic [IDX_W-1:0]         w_cur_idx;
    logic [7:0]               w_cnt_cur;
    logic [CHANNEL_WIDTH-1:0] w_cur_data;
    logic [NUM_LEAVES-1:0]    w_sel_gnt;
    logic [IDX_W-1:0]         w_sel_idx;
    logic                     w_sel_any;

    // Arbitrate when idle, or when the granted leaf has gone quiet mid-burst so the
    // next leaf can take the slot in the same cycle instead of leaving a bubble.
    always_comb begin
        w_arb      = (r_state == IDLE) || !up_rx_valid[r_grant];
        w_ptr_base = (r_state == IDLE) ? r_last_grant : r_grant;
        w_ptr      = (w_ptr_base == LAST_IDX) ? '0 : w_ptr_base + 1'b1;
    end

    rr_priority_select #(
        .N     (NUM_LEAVES),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .i_req (up_rx_valid),
        .i_ptr (w_ptr),
        .o_gnt (w_sel_gnt),
        .o_idx (w_sel_idx),
        .o_any (w_sel_any)
    );

    always_comb begin
        w_can_accept = !r_out_valid || out_ready;
        w_cur_idx    = w_arb ? w_sel_idx : r_grant;
        w_xfer       = !reset && w_can_accept && (w_arb ? w_sel_any : 1'b1);
        w_cnt_cur    = w_arb ? '0 : r_burst_cnt;
        w_burst_end  = (w_cnt_cur == BURST_LAST);

        up_rx_ready = '0;
        if (w_xfer) begin
            up_rx_ready = w_arb ? w_sel_gnt : (NUM_LEAVES'(1) << r_grant);
        end

        w_cur_data = '0;
        for (int unsigned i = 0; i < NUM_LEAVES; i++) begin
            if (w_cur_idx == IDX_W'(i)) begin
                w_cur_data = up_rx_data[CHANNEL_WIDTH*i +: CHANNEL_WIDTH];
            end
        end

        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        w_cnt_nxt   = r_burst_cnt;
        if (w_xfer) begin
            if (w_burst_end) begin
                w_state_nxt = IDLE;
                w_last_nxt  = w_cur_idx;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = BURST;
                w_grant_nxt = w_cur_idx;
                w_cnt_nxt   = w_cnt_cur + 8'd1;
                if ((r_state == BURST) && w_arb) begin
                    w_last_nxt = r_grant;
                end
            end
        end else if (w_can_accept && (r_state == BURST)) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_grant;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= LAST_IDX;
            r_burst_cnt  <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_src    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_burst_cnt  <= w_cnt_nxt;
            if (w_xfer) begin
                r_out_data  <= w_cur_data;
                r_out_valid <= 1'b1;
                r_out_src   <= w_cur_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        out_data  = r_out_data;
        out_valid = r_out_valid;
        out_src   = r_out_src;
    end

`ifdef LEAF_UPLINK_ARBITER_STATS_EN
    logic [31:0] r_grant_count [NUM_LEAVES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_LEAVES; i++) begin
                r_grant_count[i] <= '0;
            end
        end else if (w_xfer) begin
            r_grant_count[w_cur_idx] <= r_grant_count[w_cur_idx] + 32'd1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LEAVES; i++) begin
            grant_count[32*i +: 32] = r_grant_count[i];
        end
    end
`endif

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// Scoreboard bench for leaf_uplink_arbiter: accepted leaf words are queued and matched at the uplink.
module tb_leaf_uplink_arbiter;

    localparam int N  = 4;
    localparam int CW = 64;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [CW*N-1:0] up_rx_data;
    logic [N-1:0]    up_rx_valid;
    logic [N-1:0]    up_rx_ready;
    logic [CW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_src;
`ifdef LEAF_UPLINK_ARBITER_STATS_EN
    logic [32*N-1:0] grant_count;
`endif

    leaf_uplink_arbiter #(
        .NUM_LEAVES    (N),
        .CHANNEL_WIDTH (CW),
        .MAX_BURST     (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .up_rx_data  (up_rx_data),
        .up_rx_valid (up_rx_valid),
        .up_rx_ready (up_rx_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_src     (out_src)
`ifdef LEAF_UPLINK_ARBITER_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    src;
        logic [CW-1:0] data;
    } sb_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int unsigned cnt [N];
    int unsigned seq [N];
    logic [3:0]  rdy_pat = 4'hF;
    int unsigned ph    = 0;
    logic        rst_seen = 1'b0;
    sb_t         sbq [$];
    int          log_src [$];
    logic [CW-1:0] log_data [$];
    int          log_cyc [$];

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] word(input int i, input int unsigned s);
        return {8'(i), 24'hA5A5A5, 32'(s + 1)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            up_rx_valid[i]          = (cnt[i] != 0);
            up_rx_data[i*CW +: CW]  = word(i, seq[i]);
        end
        out_ready = rdy_pat[ph % 4];
    endtask

    task automatic reset_src();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            seq[i] = 0;
        end
    endtask

    task automatic clear_log();
        log_src.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic cycle();
        logic [N-1:0] acc;
        sb_t e;
        @(negedge clk);
        chk_eq("rdy_onehot", 128'($onehot0(up_rx_ready)), 1);
        if (reset) chk_eq("rst_rdy", up_rx_ready, 0);
        if (rst_seen) begin
            chk_eq("rst_valid", out_valid, 0);
            chk_eq("rst_data", out_data, 0);
            chk_eq("rst_src", out_src, 0);
            sbq.delete();
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                chk_eq("spurious_valid", out_valid, 0);
            end else begin
                e = sbq[0];
                chk_eq("out_data", out_data, e.data);
                chk_eq("out_src", out_src, e.src);
                if (out_ready) begin
                    void'(sbq.pop_front());
                    log_src.push_back(int'(out_src));
                    log_data.push_back(out_data);
                    log_cyc.push_back(cyc);
                end
            end
        end
        acc = up_rx_valid & up_rx_ready;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                e.src  = 2'(i);
                e.data = word(i, seq[i]);
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        rst_seen = reset;
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                cnt[i]--;
                seq[i]++;
            end
        end
        ph++;
        cyc++;
        drive();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (((cnt[0] | cnt[1] | cnt[2] | cnt[3]) != 0 || sbq.size() != 0 || out_valid) && k < limit) begin
            cycle();
            k++;
        end
        chk_eq("drain_in_time", k < limit, 1);
        chk_eq("sb_empty", sbq.size(), 0);
    endtask

    task automatic check_gaps(input string tag);
        for (int k = 1; k < log_cyc.size(); k++) begin
            chk_eq(tag, log_cyc[k] - log_cyc[k-1], 1);
        end
    endtask

    initial begin
        int k;
        int early_exp [5] = '{1, 1, 3, 3, 3};
        int rst_exp   [5] = '{0, 0, 0, 0, 1};

        reset = 1'b1;
        reset_src();
        for (int i = 0; i < N; i++) cnt[i] = 1000;
        drive();

        // Reset with every leaf valid, then continuous fair rotation.
        do_reset(3);
        clear_log();
        repeat (40) cycle();
        chk_eq("fair_count", log_src.size() >= 32, 1);
        for (int j = 0; j < 32; j++) begin
            if (j < log_src.size()) chk_eq("fair_src", log_src[j], (j / 4) % 4);
        end
        check_gaps("fair_gap");
        reset_src();
        drive();
        drain(100);

        // Backpressure on a single streaming leaf.
        do_reset(1);
        clear_log();
        reset_src();
        cnt[2]  = 8;
        rdy_pat = 4'b1001;
        ph      = 0;
        drive();
        drain(100);
        chk_eq("bp_count", log_src.size(), 8);
        for (int j = 0; j < log_src.size(); j++) begin
            chk_eq("bp_src", log_src[j], 2);
            chk_eq("bp_seq", log_data[j][31:0], j + 1);
        end
        rdy_pat = 4'hF;

        // Early burst end hands off to the next valid leaf without a bubble.
        do_reset(1);
        clear_log();
        reset_src();
        cnt[1] = 2;
        cnt[3] = 3;
        drive();
        drain(100);
        chk_eq("early_count", log_src.size(), 5);
        for (int j = 0; j < 5; j++) begin
            if (j < log_src.size()) chk_eq("early_src", log_src[j], early_exp[j]);
        end
        check_gaps("early_gap");

        // Reset mid-burst of leaf 1, then arbitration restarts at leaf 0.
        do_reset(1);
        clear_log();
        reset_src();
        cnt[1] = 100;
        cnt[2] = 100;
        cnt[3] = 100;
        drive();
        k = 0;
        while (log_src.size() < 2 && k < 20) begin
            cycle();
            k++;
        end
        chk_eq("mrst_in_time", k < 20, 1);
        chk_eq("mrst_pre_src", log_src.size() >= 1 ? log_src[0] : -1, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cnt[0] = 100;
        drive();
        clear_log();
        repeat (8) cycle();
        chk_eq("mrst_count", log_src.size() >= 5, 1);
        for (int j = 0; j < 5; j++) begin
            if (j < log_src.size()) chk_eq("mrst_src", log_src[j], rst_exp[j]);
        end
        reset_src();
        drive();
        drain(100);

`ifdef LEAF_UPLINK_ARBITER_STATS_EN
        do_reset(1);
        reset_src();
        cnt[0] = 100;
        cnt[3] = 37;
        drive();
        drain(400);
        chk_eq("stats_leaf0", grant_count[31:0], 100);
        chk_eq("stats_leaf1", grant_count[63:32], 0);
        chk_eq("stats_leaf2", grant_count[95:64], 0);
        chk_eq("stats_leaf3", grant_count[127:96], 37);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

endmodule
